// File: rtl/csr_regfile.sv
// Machine-mode CSR storage: old-value read for the CSR ALU, new-value writeback,
// ecall/mret trap state updates and the fetch redirect target.
module csr_regfile #(
    parameter logic [63:0] ECALL_CAUSE = 64'd11,
    parameter logic [63:0] MSTATUS_RST = 64'h1800
) (
    input  logic        I_sys_clk,
    input  logic        I_rst_n,
    input  logic [11:0] I_csr_raddr,
    output logic [63:0] O_csr_rdata,
    output logic        O_csr_illegal,
    input  logic        I_csr_wen,
    input  logic [11:0] I_csr_waddr,
    input  logic [63:0] I_csr_wdata,
    input  logic        I_ecall,
    input  logic        I_mret,
    input  logic [63:0] I_pc,
    input  logic        I_retire,
    output logic        O_redirect_valid,
    output logic [63:0] O_redirect_pc
);

    localparam int unsigned XLEN = 64;

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET = 12'hB02;

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    // Only MIE and MPIE of mstatus hold state; MPP is hardwired to M-mode.
    logic            r_mstatus_mie;
    logic            r_mstatus_mpie;
    logic [XLEN-1:0] r_mie;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mscratch;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mcycle;
    logic [XLEN-1:0] r_minstret;

    logic            w_redirect;
    logic            w_do_mret;
    logic            w_do_write;
    logic [XLEN-1:0] w_mstatus;
    logic [XLEN-1:0] w_trap_vec;

    assign w_redirect = I_ecall | I_mret;
    assign w_do_mret  = I_mret & ~I_ecall;
    assign w_do_write = I_csr_wen & ~w_redirect;
    assign w_trap_vec = r_mtvec & ALIGN_MASK;

    always_comb begin
        w_mstatus        = '0;
        w_mstatus[12:11] = 2'b11;
        w_mstatus[7]     = r_mstatus_mpie;
        w_mstatus[3]     = r_mstatus_mie;
    end

    // Combinational old-value read; writes become visible the following cycle.
    always_comb begin
        O_csr_rdata   = '0;
        O_csr_illegal = 1'b0;
        case (I_csr_raddr)
            ADDR_MSTATUS:  O_csr_rdata = w_mstatus;
            ADDR_MIE:      O_csr_rdata = r_mie;
            ADDR_MTVEC:    O_csr_rdata = r_mtvec;
            ADDR_MSCRATCH: O_csr_rdata = r_mscratch;
            ADDR_MEPC:     O_csr_rdata = r_mepc;
            ADDR_MCAUSE:   O_csr_rdata = r_mcause;
            ADDR_MIP:      O_csr_rdata = '0;
            ADDR_MCYCLE:   O_csr_rdata = r_mcycle;
            ADDR_MINSTRET: O_csr_rdata = r_minstret;
            default:       O_csr_illegal = 1'b1;
        endcase
    end

    always_comb begin
        O_redirect_valid = w_redirect;
        O_redirect_pc    = '0;
        if (I_ecall) begin
            O_redirect_pc = w_trap_vec;
        end else if (I_mret) begin
            O_redirect_pc = r_mepc;
        end
    end

    // Trap/return state and software-visible CSRs; a redirect drops any write.
    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_mstatus_mie  <= MSTATUS_RST[3];
            r_mstatus_mpie <= MSTATUS_RST[7];
            r_mie          <= '0;
            r_mtvec        <= '0;
            r_mscratch     <= '0;
            r_mepc         <= '0;
            r_mcause       <= '0;
        end else if (I_ecall) begin
            r_mepc         <= I_pc & ALIGN_MASK;
            r_mcause       <= ECALL_CAUSE;
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
        end else if (w_do_mret) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
        end else if (w_do_write) begin
            case (I_csr_waddr)
                ADDR_MSTATUS: begin
                    r_mstatus_mie  <= I_csr_wdata[3];
                    r_mstatus_mpie <= I_csr_wdata[7];
                end
                ADDR_MIE:      r_mie      <= I_csr_wdata;
                ADDR_MTVEC:    r_mtvec    <= I_csr_wdata;
                ADDR_MSCRATCH: r_mscratch <= I_csr_wdata;
                ADDR_MEPC:     r_mepc     <= I_csr_wdata & ALIGN_MASK;
                ADDR_MCAUSE:   r_mcause   <= I_csr_wdata;
                default:       ;
            endcase
        end
    end

    // Free-running cycle counter; a write replaces that cycle's increment.
    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_mcycle <= '0;
        end else if (w_do_write && (I_csr_waddr == ADDR_MCYCLE)) begin
            r_mcycle <= I_csr_wdata;
        end else begin
            r_mcycle <= r_mcycle + XLEN'(1);
        end
    end

    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_minstret <= '0;
        end else if (w_do_write && (I_csr_waddr == ADDR_MINSTRET)) begin
            r_minstret <= I_csr_wdata;
        end else if (I_retire) begin
            r_minstret <= r_minstret + XLEN'(1);
        end
    end

endmodule
